// File: rtl/xalu_pkg.sv
// Shared command codes, default latencies and counter width for the multiply/divide unit.
package xalu_pkg;

  localparam logic [3:0] XOP_NONE  = 4'd0;
  localparam logic [3:0] XOP_MTLO  = 4'd1;
  localparam logic [3:0] XOP_MTHI  = 4'd2;
  localparam logic [3:0] XOP_DIVU  = 4'd3;
  localparam logic [3:0] XOP_DIV   = 4'd4;
  localparam logic [3:0] XOP_MULTU = 4'd5;
  localparam logic [3:0] XOP_MULT  = 4'd6;
  localparam logic [3:0] XOP_MFLO  = 4'd7;
  localparam logic [3:0] XOP_MFHI  = 4'd8;
  localparam logic [3:0] XOP_MADD  = 4'd9;
  localparam logic [3:0] XOP_MADDU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

  function automatic logic is_div_op(logic [3:0] op);
    return (op == XOP_DIV) || (op == XOP_DIVU);
  endfunction

endpackage

// File: rtl/xalu_md_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu/madd/maddu.
module xalu_md_calc
  import xalu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div0_o
);

  logic        sgn, a_neg, b_neg;
  logic [63:0] mul_a, mul_b, prod, acc;
  logic [31:0] dvd, dvs, dvs_nz, q_mag, r_mag, q_fix, r_fix;

  always_comb begin
    sgn   = (op_i == XOP_DIV) || (op_i == XOP_MULT) || (op_i == XOP_MADD);
    a_neg = sgn && a_i[31];
    b_neg = sgn && b_i[31];

    mul_a = {{32{a_neg}}, a_i};
    mul_b = {{32{b_neg}}, b_i};
    prod  = mul_a * mul_b;
    acc   = {hi_i, lo_i} + prod;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    dvd    = a_neg ? (~a_i + 32'd1) : a_i;
    dvs    = b_neg ? (~b_i + 32'd1) : b_i;
    dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
    q_mag  = dvd / dvs_nz;
    r_mag  = dvd % dvs_nz;
    q_fix  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_fix  = a_neg ? (~r_mag + 32'd1) : r_mag;

    div0_o = is_div_op(op_i) && (b_i == 32'd0);

    if (is_div_op(op_i)) begin
      res_hi_o = r_fix;
      res_lo_o = q_fix;
    end else if ((op_i == XOP_MADD) || (op_i == XOP_MADDU)) begin
      res_hi_o = acc[63:32];
      res_lo_o = acc[31:0];
    end else begin
      res_hi_o = prod[63:32];
      res_lo_o = prod[31:0];
    end
  end

endmodule

// File: rtl/xalu_md.sv
// Multiply/divide unit owning HI/LO; multi-cycle ops commit from shadow registers.
// Define XALU_MADD_EN to enable madd (9) / maddu (10).
module xalu_md
  import xalu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  xaluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d, sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, div0_q, div0_d;
  logic             md_op;
  logic [31:0]      res_hi, res_lo;
  logic             res_div0;

  xalu_md_calc u_calc (
    .op_i    (xaluop),
    .a_i     (a),
    .b_i     (b),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .res_hi_o(res_hi),
    .res_lo_o(res_lo),
    .div0_o  (res_div0)
  );

  always_comb begin
    md_op = 1'b0;
    case (xaluop)
      XOP_DIVU, XOP_DIV, XOP_MULTU, XOP_MULT: md_op = 1'b1;
`ifdef XALU_MADD_EN
      XOP_MADD, XOP_MADDU:                    md_op = 1'b1;
`endif
      default:                                md_op = 1'b0;
    endcase
  end

  assign start = md_op && !busy_q;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    div0_d  = div0_q;
    if (start) begin
      sh_hi_d = res_hi;
      sh_lo_d = res_lo;
      div0_d  = res_div0;
      cnt_d   = is_div_op(xaluop) ? DivLoad : MultLoad;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      // mthi/mtlo are dropped while busy; the hazard unit never lets them through legally.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (!div0_q) begin
          hi_d = sh_hi_q;
          lo_d = sh_lo_q;
        end
      end
    end else if (xaluop == XOP_MTHI) begin
      hi_d = a;
    end else if (xaluop == XOP_MTLO) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    case (xaluop)
      XOP_MFHI: rdata = hi_q;
      XOP_MFLO: rdata = lo_q;
      default:  rdata = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Idle code is decoded implicitly by the default arms above.
  logic unused_none;
  assign unused_none = (xaluop == XOP_NONE);

endmodule

// File: tb/tb_xalu_md.sv
// Scoreboard bench for xalu_md: driver models HI/LO architecturally, monitor checks every cycle.
module tb_xalu_md;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  xaluop = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        start, busy;
  logic [31:0] hi, lo, rdata;

  xalu_md #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .xaluop (xaluop),
    .a      (a),
    .b      (b),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } sb_t;
  sb_t sb_q[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic exp_busy = 1'b0;
  logic [31:0] sb_hi = '0, sb_lo = '0;

  // Architectural model
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        pend_v = 1'b0, pend_d0 = 1'b0;
  int          pend_e = 0;
  logic [31:0] pend_hi = '0, pend_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic is_md(input logic [3:0] op);
`ifdef XALU_MADD_EN
    return (op >= 4'd3 && op <= 4'd6) || op == 4'd9 || op == 4'd10;
`else
    return op >= 4'd3 && op <= 4'd6;
`endif
  endfunction

  task automatic model_md(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] r;
    int sa, sbv;
    pend_d0 = 1'b0;
    r = {m_hi, m_lo};
    sa = av;
    sbv = bv;
    case (op)
      4'd6:  r = longint'($signed(av)) * longint'($signed(bv));
      4'd5:  r = 64'(av) * 64'(bv);
      4'd9:  r = {m_hi, m_lo} + longint'($signed(av)) * longint'($signed(bv));
      4'd10: r = {m_hi, m_lo} + 64'(av) * 64'(bv);
      4'd3: begin
        if (bv == 0) pend_d0 = 1'b1;
        else r = {av % bv, av / bv};
      end
      default: begin
        if (bv == 0) pend_d0 = 1'b1;
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sbv), 32'(sa / sbv)};
      end
    endcase
    pend_hi = r[63:32];
    pend_lo = r[31:0];
  endtask

  task automatic push_state(input int e);
    sb_q.push_back('{due: e, hi: m_hi, lo: m_lo});
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                      input logic rn);
    int e;
    logic exp_start;
    logic [31:0] exp_rd;
    @(negedge clk);
    xaluop = op; a = av; b = bv; reset_n = rn;
    #1;
    e = cyc + 1;
    exp_start = is_md(op) && !pend_v;
    exp_rd = (op == 4'd8) ? m_hi : (op == 4'd7) ? m_lo : 32'd0;
    if (mon_en) begin
      chk("start", start, exp_start);
      chk("rdata", rdata, exp_rd);
    end
    if (!rn) begin
      pend_v = 1'b0; m_hi = '0; m_lo = '0;
      sb_q.delete();
      push_state(e);
    end else if (pend_v) begin
      if (pend_e == e) begin
        if (!pend_d0) begin m_hi = pend_hi; m_lo = pend_lo; end
        pend_v = 1'b0;
        push_state(e);
      end
    end else if (exp_start) begin
      model_md(op, av, bv);
      pend_v = 1'b1;
      pend_e = e + ((op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N);
    end else if (op == 4'd2) begin
      m_hi = av; push_state(e);
    end else if (op == 4'd1) begin
      m_lo = av; push_state(e);
    end
    exp_busy = pend_v;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, $urandom, $urandom, 1'b1);
  endtask

  task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    #1;
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: retires scoreboard entries at their due edge and checks visible state every cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (mon_en) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          sb_hi = sb_q[0].hi;
          sb_lo = sb_q[0].lo;
          void'(sb_q.pop_front());
        end
        chk("busy", busy, exp_busy);
        chk("hi", hi, sb_hi);
        chk("lo", lo, sb_lo);
      end
    end
  end

  initial begin
    step(4'd0, '0, '0, 1'b0);
    mon_en = 1'b1;
    step(4'd0, '0, '0, 1'b0);

    // mult -3 * 5, mfhi during busy returns old hi
    step(4'd6, 32'hFFFF_FFFD, 32'd5, 1'b1);
    for (int i = 0; i < MULT_N; i++) step(4'd8, '0, '0, 1'b1);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    step(4'd3, 32'd7, 32'd2, 1'b1);
    idle(DIV_N);
    chk_hilo("divu", 32'd1, 32'd3);

    step(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(DIV_N);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    step(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(DIV_N);
    chk_hilo("div_ovf", 32'd0, 32'h8000_0000);

    // divide by zero keeps HI/LO
    step(4'd2, 32'h1234, '0, 1'b1);
    step(4'd4, 32'd99, 32'd0, 1'b1);
    idle(DIV_N);
    chk_hilo("div0", 32'h1234, 32'h8000_0000);

    // writes and md commands while busy are ignored
    step(4'd6, 32'd6, 32'd7, 1'b1);
    step(4'd1, 32'hAA, '0, 1'b1);
    step(4'd5, 32'd3, 32'd3, 1'b1);
    idle(MULT_N);
    chk_hilo("busy_ign", 32'd0, 32'd42);

    // reset mid-divide discards the operation
    step(4'd3, 32'd100, 32'd7, 1'b1);
    idle(2);
    step(4'd0, '0, '0, 1'b0);
    idle(DIV_N + 2);
    chk_hilo("rst_mid", 32'd0, 32'd0);

    // maddu wrap into HI, or no-op without the feature
    step(4'd2, 32'd0, '0, 1'b1);
    step(4'd1, 32'hFFFF_FFFF, '0, 1'b1);
    step(4'd10, 32'd1, 32'd1, 1'b1);
    idle(MULT_N);
`ifdef XALU_MADD_EN
    chk_hilo("maddu", 32'd1, 32'd0);
`else
    chk_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 2500; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 12));
      step(op, rnd_operand(), rnd_operand(), ($urandom_range(0, 299) != 0));
    end

    idle(DIV_N + 3);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
